// File: rtl/ifu_if.sv
// Instruction bus between the fetch unit (master) and instruction memory (slave).
// Grant/valid protocol: responses return in request order.
interface ifu_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: PC, in-order fetch over the grant/valid bus, 2-entry instruction
// FIFO toward if_id, with stall handling and redirect-driven discard of wrong-path responses.
module ifu #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  jump_flag_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  ifu_if.master                 ibus,
  output logic                  inst_valid_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o
);
  localparam logic [DATA_WIDTH-1:0] Nop = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            live_q, live_d;
  logic [1:0]            drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] fa_q [2];
  logic [ADDR_WIDTH-1:0] fa_d [2];
  logic [DATA_WIDTH-1:0] fi_q [2];
  logic [DATA_WIDTH-1:0] fi_d [2];
  logic [ADDR_WIDTH-1:0] aq_q [2];
  logic [ADDR_WIDTH-1:0] aq_d [2];

  logic       gnt, pop, rsp_live, rsp_drop, rsp_any;
  logic       fifo_wr, aq_wr;
  logic [2:0] credit;

  always_comb begin
    inst_valid_o = !rst_i && !jump_flag_i && (cnt_q != 2'd0);
    inst_o       = inst_valid_o ? fi_q[0] : Nop;
    inst_addr_o  = inst_valid_o ? fa_q[0] : '0;
    pop          = inst_valid_o && !stall_i;
    // Outstanding plus buffered words may never exceed the FIFO depth.
    credit       = 3'(live_q) + 3'(drop_q) + 3'(cnt_q) - 3'(pop);
    ibus.req     = !rst_i && !jump_flag_i && (credit < 3'd2);
    ibus.addr    = pc_q;
    gnt          = ibus.req && ibus.gnt;
    rsp_drop     = ibus.rvalid && (state_q == StDrain);
    rsp_live     = ibus.rvalid && (state_q == StRun) && (live_q != 2'd0);
    rsp_any      = rsp_drop || rsp_live;
    fifo_wr      = (cnt_q == 2'd1) && !pop;
    aq_wr        = (live_q == 2'd1) && !rsp_live;
  end

  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    live_d = live_q;
    drop_d = drop_q;
    fa_d   = fa_q;
    fi_d   = fi_q;
    aq_d   = aq_q;
    if (jump_flag_i) begin
      pc_d   = jump_addr_i & ~ADDR_WIDTH'(3);
      cnt_d  = '0;
      live_d = '0;
      // Everything still in flight becomes wrong-path.
      drop_d = drop_q + live_q + 2'(gnt) - 2'(rsp_any);
    end else begin
      if (gnt) pc_d = pc_q + ADDR_WIDTH'(4);
      if (rsp_live) aq_d[0] = aq_q[1];
      if (gnt) aq_d[aq_wr] = pc_q;
      live_d = live_q + 2'(gnt) - 2'(rsp_live);
      if (rsp_drop) drop_d = drop_q - 2'd1;
      if (pop) begin
        fa_d[0] = fa_q[1];
        fi_d[0] = fi_q[1];
      end
      if (rsp_live) begin
        fa_d[fifo_wr] = aq_q[0];
        fi_d[fifo_wr] = ibus.rdata;
      end
      cnt_d = cnt_q + 2'(rsp_live) - 2'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (jump_flag_i && (drop_d != 2'd0)) state_d = StDrain;
      StDrain: if (drop_d == 2'd0) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRun;
      pc_q    <= RESET_ADDR;
      cnt_q   <= '0;
      live_q  <= '0;
      drop_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        fa_q[i] <= '0;
        fi_q[i] <= '0;
        aq_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      live_q  <= live_d;
      drop_q  <= drop_d;
      fa_q    <= fa_d;
      fi_q    <= fi_d;
      aq_q    <= aq_d;
    end
  end
endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: in-order memory model with variable latency, directed timing checks and a
// randomized phase scored against the expected architectural fetch stream.
module tb_ifu;
  localparam logic [31:0] RstAddr = 32'hFFFF_FFF8;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, jump;
  logic [31:0] jump_addr;
  logic        inst_valid;
  logic [31:0] inst, inst_addr;

  ifu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ibus ();

  ifu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_ADDR(RstAddr)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .jump_flag_i  (jump),
    .jump_addr_i  (jump_addr),
    .ibus         (ibus),
    .inst_valid_o (inst_valid),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int pops   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Expected architectural stream: sequential words from the last reset/redirect target.
  logic [31:0] exp_q[$];
  logic [31:0] exp_tail;

  function automatic void sb_fill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 32'd4;
    end
  endfunction

  function automatic void sb_restart(input logic [31:0] a);
    exp_q.delete();
    exp_tail = {a[31:2], 2'b00};
    sb_fill();
  endfunction

  // Memory model
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] cyc = '0;
  logic [31:0] last_due = '0;
  int unsigned lat = 1;
  int unsigned gnt_pct = 100;
  int unsigned stall_pct = 0;
  bit          gnt_off = 1'b0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  initial begin
    mreq_t r;
    ibus.gnt    = 1'b0;
    ibus.rvalid = 1'b0;
    ibus.rdata  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        mq.delete();
        ibus.gnt    = 1'b0;
        ibus.rvalid = 1'b0;
      end else begin
        ibus.gnt = !gnt_off && ($urandom_range(99) < gnt_pct);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
          ibus.rvalid = 1'b1;
          ibus.rdata  = mem_data(mq[0].addr);
        end else begin
          ibus.rvalid = 1'b0;
          ibus.rdata  = $urandom;
        end
      end
      #1;
      if (!rst) begin
        if (ibus.req && ibus.gnt) begin
          check("outstanding_limit", 32'(mq.size() < 2), 32'd1);
          r.addr = ibus.addr;
          r.due  = cyc + lat;
          if (mq.size() > 0 && r.due <= last_due) r.due = last_due + 32'd1;
          last_due = r.due;
        end
        if (ibus.rvalid) void'(mq.pop_front());
        if (ibus.req && ibus.gnt) mq.push_back(r);
      end
    end
  end

  // Monitor: scoreboard pops and output-rule checks
  logic        hold = 1'b0;
  logic        prev_jump = 1'b0;
  logic [31:0] p_inst, p_addr, exp_a;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_req", 32'(ibus.req), 32'd0);
        check("rst_inst", inst, Nop);
        check("rst_addr", inst_addr, 32'd0);
        hold      = 1'b0;
        prev_jump = 1'b0;
      end else if (jump) begin
        check("jump_valid", 32'(inst_valid), 32'd0);
        check("jump_req", 32'(ibus.req), 32'd0);
        hold      = 1'b0;
        prev_jump = 1'b1;
      end else begin
        if (prev_jump) check("post_jump_valid", 32'(inst_valid), 32'd0);
        if (hold) begin
          check("stall_valid", 32'(inst_valid), 32'd1);
          check("stall_inst", inst, p_inst);
          check("stall_addr", inst_addr, p_addr);
        end
        if (!inst_valid) begin
          check("idle_inst", inst, Nop);
          check("idle_addr", inst_addr, 32'd0);
        end
        if (inst_valid && !stall) begin
          sb_fill();
          exp_a = exp_q.pop_front();
          check("sb_addr", inst_addr, exp_a);
          check("sb_inst", inst, mem_data(exp_a));
          pops++;
        end
        hold      = inst_valid && stall;
        p_inst    = inst;
        p_addr    = inst_addr;
        prev_jump = 1'b0;
      end
    end
  end

  // Stimulus
  int p0;

  initial begin
    rst = 1'b1; stall = 1'b0; jump = 1'b0; jump_addr = '0;
    sb_restart(RstAddr);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #4;
      if (k == 0) begin
        check("first_req", 32'(ibus.req), 32'd1);
        check("first_addr", ibus.addr, RstAddr);
      end
      check("latency_valid", 32'(inst_valid), 32'(k >= 2));
      @(negedge clk);
    end
    #4;
    p0 = pops;
    repeat (20) @(negedge clk);
    #4;
    check("throughput", 32'(pops - p0), 32'd20);

    // Stall: FIFO fills and requests stop
    @(negedge clk);
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #4;
      if (s >= 1) check("stall_req_off", 32'(ibus.req), 32'd0);
      @(negedge clk);
    end
    stall = 1'b0;
    repeat (4) @(negedge clk);

    // Redirect with slow memory: in-flight responses dropped
    lat = 3;
    repeat (8) @(negedge clk);
    jump = 1'b1; jump_addr = 32'h0000_0103; sb_restart(32'h0000_0103);
    @(negedge clk);
    jump = 1'b0;
    #4;
    check("redirect_addr", ibus.addr, 32'h0000_0100);
    @(negedge clk);
    #4;
    check("redirect_n2_valid", 32'(inst_valid), 32'd0);
    repeat (15) @(negedge clk);
    lat = 1;
    repeat (4) @(negedge clk);

    // Grant withheld: PC holds, nothing valid
    gnt_off = 1'b1;
    jump = 1'b1; jump_addr = 32'h0000_0200; sb_restart(32'h0000_0200);
    @(negedge clk);
    jump = 1'b0;
    for (int g = 0; g < 5; g++) begin
      #4;
      check("nognt_addr", ibus.addr, 32'h0000_0200);
      check("nognt_valid", 32'(inst_valid), 32'd0);
      @(negedge clk);
    end
    gnt_off = 1'b0;
    repeat (10) @(negedge clk);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        lat       = $urandom_range(3, 1);
        gnt_pct   = $urandom_range(100, 40);
        stall_pct = $urandom_range(60, 0);
      end
      stall = $urandom_range(99) < stall_pct;
      if ($urandom_range(499) == 0) begin
        rst  = 1'b1;
        jump = 1'b0;
        sb_restart(RstAddr);
      end else begin
        rst  = 1'b0;
        jump = $urandom_range(99) < 4;
        if (jump) begin
          jump_addr = $urandom;
          sb_restart(jump_addr);
        end
      end
      @(negedge clk);
    end
    rst = 1'b0; jump = 1'b0; stall = 1'b0;
    repeat (30) @(negedge clk);
    check("activity", 32'(pops > 500), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
